// File: rtl/msi_pkg.sv
// Shared encodings for the MSI cache controller: line states, bus commands
// and the controller FSM states.
package msi_pkg;

   localparam logic [1:0] ST_I = 2'b00;
   localparam logic [1:0] ST_S = 2'b01;
   localparam logic [1:0] ST_M = 2'b10;

   localparam logic [2:0] CMD_NONE    = 3'd0;
   localparam logic [2:0] CMD_RD_MISS = 3'd1;
   localparam logic [2:0] CMD_WR_MISS = 3'd2;
   localparam logic [2:0] CMD_INV     = 3'd3;
   localparam logic [2:0] CMD_WB      = 3'd4;

   typedef enum logic [2:0] {
      FSM_IDLE,
      FSM_WB,
      FSM_MISS,
      FSM_UPG,
      FSM_DONE
   } fsm_state_e;

   function automatic logic [2:0] miss_cmd(input logic write);
      return write ? CMD_WR_MISS : CMD_RD_MISS;
   endfunction

endpackage

// File: rtl/msi_line_store.sv
// Per-line MSI state and tag arrays. The FSM write for this edge is applied
// first and the snoop result on top of it, so snoops always win.
module msi_line_store
   import msi_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int NUM_LINES = 4,
   parameter int IDX_W     = $clog2(NUM_LINES),
   parameter int TAG_W     = ADDR_W - IDX_W
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [IDX_W-1:0]  cpu_idx,
   output logic [1:0]        cpu_state,
   output logic [TAG_W-1:0]  cpu_tag,
   output logic [1:0]        cpu_state_nxt,
   input  logic              fsm_we,
   input  logic [1:0]        fsm_state,
   input  logic              fsm_tag_we,
   input  logic [TAG_W-1:0]  fsm_tag,
   input  logic              snoop_valid,
   input  logic [2:0]        snoop_cmd,
   input  logic [ADDR_W-1:0] snoop_addr,
   output logic              snoop_flush,
   input  logic [IDX_W-1:0]  dbg_index,
   output logic [1:0]        dbg_state
);

   logic [1:0]       state_q [NUM_LINES];
   logic [1:0]       state_d [NUM_LINES];
   logic [TAG_W-1:0] tag_q   [NUM_LINES];
   logic [TAG_W-1:0] tag_d   [NUM_LINES];
   logic [IDX_W-1:0] snp_idx;
   logic [TAG_W-1:0] snp_tag;

   assign snp_idx   = snoop_addr[IDX_W-1:0];
   assign snp_tag   = snoop_addr[ADDR_W-1:IDX_W];
   assign cpu_state = state_q[cpu_idx];
   assign cpu_tag   = tag_q[cpu_idx];
   assign dbg_state = state_q[dbg_index];

   always_comb begin
      state_d     = state_q;
      tag_d       = tag_q;
      snoop_flush = 1'b0;
      if (fsm_we) begin
         state_d[cpu_idx] = fsm_state;
      end
      if (fsm_tag_we) begin
         tag_d[cpu_idx] = fsm_tag;
      end
      // Snoop is evaluated against the line as it looks after the FSM update
      if (snoop_valid && (state_d[snp_idx] != ST_I) && (tag_d[snp_idx] == snp_tag)) begin
         case (snoop_cmd)
            CMD_RD_MISS: begin
               if (state_d[snp_idx] == ST_M) begin
                  state_d[snp_idx] = ST_S;
                  snoop_flush      = 1'b1;
               end
            end
            CMD_WR_MISS: begin
               snoop_flush      = (state_d[snp_idx] == ST_M);
               state_d[snp_idx] = ST_I;
            end
            CMD_INV: begin
               state_d[snp_idx] = ST_I;
            end
            default: begin
            end
         endcase
      end
      cpu_state_nxt = state_d[cpu_idx];
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            state_q[i] <= ST_I;
            tag_q[i]   <= '0;
         end
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
      end
   end

endmodule

// File: rtl/msi_cache_ctrl.sv
// Direct-mapped MSI coherence controller: serves CPU requests, drives the
// snooping bus through req/ack, and applies snooped commands to its lines.
module msi_cache_ctrl
   import msi_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int NUM_LINES = 4
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic                         cpu_req,
   input  logic                         cpu_write,
   input  logic [ADDR_W-1:0]            cpu_addr,
   output logic                         cpu_done,
   output logic                         cpu_hit,
   output logic                         bus_req,
   output logic [2:0]                   bus_cmd,
   output logic [ADDR_W-1:0]            bus_addr,
   input  logic                         bus_ack,
   input  logic                         snoop_valid,
   input  logic [2:0]                   snoop_cmd,
   input  logic [ADDR_W-1:0]            snoop_addr,
   output logic                         snoop_wb,
   input  logic [$clog2(NUM_LINES)-1:0] dbg_index,
   output logic [1:0]                   dbg_state
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - IDX_W;

   fsm_state_e        state_q, state_d;
   logic              bus_req_q, bus_req_d;
   logic [2:0]        bus_cmd_q, bus_cmd_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic              cpu_done_q, cpu_done_d;
   logic              cpu_hit_q, cpu_hit_d;
   logic              snoop_wb_q;

   logic [IDX_W-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic [1:0]        line_state;
   logic [TAG_W-1:0]  line_tag;
   logic [1:0]        line_state_nxt;
   logic              line_hit;
   logic              fsm_we;
   logic [1:0]        fsm_wr_state;
   logic              fsm_tag_we;
   logic              snoop_flush;

   assign req_idx  = cpu_addr[IDX_W-1:0];
   assign req_tag  = cpu_addr[ADDR_W-1:IDX_W];
   assign line_hit = (line_state != ST_I) && (line_tag == req_tag);

   msi_line_store #(
      .ADDR_W    (ADDR_W),
      .NUM_LINES (NUM_LINES)
   ) u_store (
      .clock         (clock),
      .resetn        (resetn),
      .cpu_idx       (req_idx),
      .cpu_state     (line_state),
      .cpu_tag       (line_tag),
      .cpu_state_nxt (line_state_nxt),
      .fsm_we        (fsm_we),
      .fsm_state     (fsm_wr_state),
      .fsm_tag_we    (fsm_tag_we),
      .fsm_tag       (req_tag),
      .snoop_valid   (snoop_valid),
      .snoop_cmd     (snoop_cmd),
      .snoop_addr    (snoop_addr),
      .snoop_flush   (snoop_flush),
      .dbg_index     (dbg_index),
      .dbg_state     (dbg_state)
   );

   always_comb begin
      state_d      = state_q;
      bus_req_d    = bus_req_q;
      bus_cmd_d    = bus_cmd_q;
      bus_addr_d   = bus_addr_q;
      cpu_done_d   = 1'b0;
      cpu_hit_d    = 1'b0;
      fsm_we       = 1'b0;
      fsm_wr_state = ST_I;
      fsm_tag_we   = 1'b0;
      case (state_q)
         FSM_IDLE: begin
            if (cpu_req && !snoop_valid) begin
               if (line_hit && (!cpu_write || (line_state == ST_M))) begin
                  state_d    = FSM_DONE;
                  cpu_done_d = 1'b1;
                  cpu_hit_d  = 1'b1;
               end else if (line_hit) begin
                  state_d    = FSM_UPG;
                  bus_req_d  = 1'b1;
                  bus_cmd_d  = CMD_INV;
                  bus_addr_d = cpu_addr;
               end else if (line_state == ST_M) begin
                  state_d    = FSM_WB;
                  bus_req_d  = 1'b1;
                  bus_cmd_d  = CMD_WB;
                  bus_addr_d = {line_tag, req_idx};
               end else begin
                  state_d    = FSM_MISS;
                  bus_req_d  = 1'b1;
                  bus_cmd_d  = miss_cmd(cpu_write);
                  bus_addr_d = cpu_addr;
               end
            end
         end
         // A snoop that already invalidated the victim makes the write-back moot
         FSM_WB: begin
            if (bus_ack || (line_state_nxt == ST_I)) begin
               fsm_we     = bus_ack;
               state_d    = FSM_MISS;
               bus_cmd_d  = miss_cmd(cpu_write);
               bus_addr_d = cpu_addr;
            end
         end
         FSM_MISS: begin
            if (bus_ack) begin
               fsm_we       = 1'b1;
               fsm_wr_state = cpu_write ? ST_M : ST_S;
               fsm_tag_we   = 1'b1;
               state_d      = FSM_DONE;
               cpu_done_d   = 1'b1;
               bus_req_d    = 1'b0;
               bus_cmd_d    = CMD_NONE;
               bus_addr_d   = '0;
            end
         end
         // Losing the S copy mid-upgrade turns the INV into a full write miss
         FSM_UPG: begin
            if (bus_ack) begin
               fsm_we       = 1'b1;
               fsm_wr_state = ST_M;
               state_d      = FSM_DONE;
               cpu_done_d   = 1'b1;
               bus_req_d    = 1'b0;
               bus_cmd_d    = CMD_NONE;
               bus_addr_d   = '0;
            end else if (line_state_nxt == ST_I) begin
               state_d   = FSM_MISS;
               bus_cmd_d = CMD_WR_MISS;
            end
         end
         FSM_DONE: begin
            state_d = FSM_IDLE;
         end
         default: begin
            state_d = FSM_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= FSM_IDLE;
         bus_req_q  <= 1'b0;
         bus_cmd_q  <= CMD_NONE;
         bus_addr_q <= '0;
         cpu_done_q <= 1'b0;
         cpu_hit_q  <= 1'b0;
         snoop_wb_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bus_req_q  <= bus_req_d;
         bus_cmd_q  <= bus_cmd_d;
         bus_addr_q <= bus_addr_d;
         cpu_done_q <= cpu_done_d;
         cpu_hit_q  <= cpu_hit_d;
         snoop_wb_q <= snoop_flush;
      end
   end

   assign cpu_done = cpu_done_q;
   assign cpu_hit  = cpu_hit_q;
   assign bus_req  = bus_req_q;
   assign bus_cmd  = bus_cmd_q;
   assign bus_addr = bus_addr_q;
   assign snoop_wb = snoop_wb_q;

endmodule

// File: tb/tb_msi_cache_ctrl.sv
// Directed bench for msi_cache_ctrl: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_msi_cache_ctrl;

   logic       clock = 1'b0;
   logic       resetn;
   logic       cpu_req;
   logic       cpu_write;
   logic [7:0] cpu_addr;
   logic       cpu_done;
   logic       cpu_hit;
   logic       bus_req;
   logic [2:0] bus_cmd;
   logic [7:0] bus_addr;
   logic       bus_ack;
   logic       snoop_valid;
   logic [2:0] snoop_cmd;
   logic [7:0] snoop_addr;
   logic       snoop_wb;
   logic [1:0] dbg_index;
   logic [1:0] dbg_state;

   int vectors = 0;
   int miscompares = 0;

   msi_cache_ctrl #(
      .ADDR_W    (8),
      .NUM_LINES (4)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .cpu_req     (cpu_req),
      .cpu_write   (cpu_write),
      .cpu_addr    (cpu_addr),
      .cpu_done    (cpu_done),
      .cpu_hit     (cpu_hit),
      .bus_req     (bus_req),
      .bus_cmd     (bus_cmd),
      .bus_addr    (bus_addr),
      .bus_ack     (bus_ack),
      .snoop_valid (snoop_valid),
      .snoop_cmd   (snoop_cmd),
      .snoop_addr  (snoop_addr),
      .snoop_wb    (snoop_wb),
      .dbg_index   (dbg_index),
      .dbg_state   (dbg_state)
   );

   always #5 clock = ~clock;

   // Advance one cycle and settle just after the rising edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic req, input logic write, input logic [7:0] addr);
      cpu_req   = req;
      cpu_write = write;
      cpu_addr  = addr;
   endtask

   task automatic applySnoop(input logic valid, input logic [2:0] cmd, input logic [7:0] addr);
      snoop_valid = valid;
      snoop_cmd   = cmd;
      snoop_addr  = addr;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
         $error("[TB] miscompare on %s", tag);
      end
   endtask

   task automatic checkLine(input string tag, input logic [1:0] idx, input logic [1:0] expected);
      dbg_index = idx;
      #1;
      checkOutput(tag, 32'(dbg_state), 32'(expected));
   endtask

   initial begin
      #20000;
      $display("[TB] FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      resetn = 1'b0;
      bus_ack = 1'b0;
      dbg_index = 2'd0;
      applyStimulus(1'b0, 1'b0, 8'h00);
      applySnoop(1'b0, 3'd0, 8'h00);
      step();
      step();

      checkOutput("rst_cpu_done", 32'(cpu_done), 32'd0);
      checkOutput("rst_cpu_hit", 32'(cpu_hit), 32'd0);
      checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
      checkOutput("rst_bus_cmd", 32'(bus_cmd), 32'd0);
      checkOutput("rst_bus_addr", 32'(bus_addr), 32'd0);
      checkOutput("rst_snoop_wb", 32'(snoop_wb), 32'd0);
      for (int i = 0; i < 4; i++) begin
         checkLine("rst_line", 2'(i), 2'b00);
      end
      resetn = 1'b1;
      step();

      $display("[TB] read miss then read hit at 0x05");
      applyStimulus(1'b1, 1'b0, 8'h05);
      step();
      checkOutput("rdmiss_req", 32'(bus_req), 32'd1);
      checkOutput("rdmiss_cmd", 32'(bus_cmd), 32'd1);
      checkOutput("rdmiss_addr", 32'(bus_addr), 32'h05);
      step();
      checkOutput("rdmiss_hold_req", 32'(bus_req), 32'd1);
      checkOutput("rdmiss_no_done", 32'(cpu_done), 32'd0);
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      checkOutput("rdmiss_done", 32'(cpu_done), 32'd1);
      checkOutput("rdmiss_hit", 32'(cpu_hit), 32'd0);
      checkOutput("rdmiss_req_drop", 32'(bus_req), 32'd0);
      checkLine("rdmiss_line", 2'd1, 2'b01);
      applyStimulus(1'b0, 1'b0, 8'h05);
      step();
      checkOutput("done_one_cycle", 32'(cpu_done), 32'd0);
      applyStimulus(1'b1, 1'b0, 8'h05);
      step();
      checkOutput("rdhit_done", 32'(cpu_done), 32'd1);
      checkOutput("rdhit_hit", 32'(cpu_hit), 32'd1);
      checkOutput("rdhit_no_bus", 32'(bus_req), 32'd0);
      applyStimulus(1'b0, 1'b0, 8'h05);
      step();

      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      checkOutput("stray_ack_req", 32'(bus_req), 32'd0);
      checkOutput("stray_ack_done", 32'(cpu_done), 32'd0);

      $display("[TB] write upgrade at 0x05");
      applyStimulus(1'b1, 1'b1, 8'h05);
      step();
      checkOutput("upg_req", 32'(bus_req), 32'd1);
      checkOutput("upg_cmd", 32'(bus_cmd), 32'd3);
      checkOutput("upg_addr", 32'(bus_addr), 32'h05);
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      checkOutput("upg_done", 32'(cpu_done), 32'd1);
      checkOutput("upg_hit", 32'(cpu_hit), 32'd0);
      checkLine("upg_line", 2'd1, 2'b10);
      applyStimulus(1'b0, 1'b1, 8'h05);
      step();
      applyStimulus(1'b1, 1'b1, 8'h05);
      step();
      checkOutput("wrhit_done", 32'(cpu_done), 32'd1);
      checkOutput("wrhit_hit", 32'(cpu_hit), 32'd1);
      checkOutput("wrhit_no_bus", 32'(bus_req), 32'd0);
      applyStimulus(1'b0, 1'b1, 8'h05);
      step();

      $display("[TB] dirty victim write-back then read miss at 0x09");
      applyStimulus(1'b1, 1'b0, 8'h09);
      step();
      checkOutput("wb_req", 32'(bus_req), 32'd1);
      checkOutput("wb_cmd", 32'(bus_cmd), 32'd4);
      checkOutput("wb_addr", 32'(bus_addr), 32'h05);
      bus_ack = 1'b1;
      step();
      checkOutput("wb_miss_req", 32'(bus_req), 32'd1);
      checkOutput("wb_miss_cmd", 32'(bus_cmd), 32'd1);
      checkOutput("wb_miss_addr", 32'(bus_addr), 32'h09);
      checkLine("wb_victim_inv", 2'd1, 2'b00);
      step();
      bus_ack = 1'b0;
      checkOutput("wb_miss_done", 32'(cpu_done), 32'd1);
      checkOutput("wb_miss_hit", 32'(cpu_hit), 32'd0);
      checkLine("wb_miss_line", 2'd1, 2'b01);
      applyStimulus(1'b0, 1'b0, 8'h09);
      step();

      $display("[TB] write miss over clean victim at 0x05");
      applyStimulus(1'b1, 1'b1, 8'h05);
      step();
      checkOutput("wrmiss_cmd", 32'(bus_cmd), 32'd2);
      checkOutput("wrmiss_addr", 32'(bus_addr), 32'h05);
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      checkOutput("wrmiss_done", 32'(cpu_done), 32'd1);
      checkLine("wrmiss_line", 2'd1, 2'b10);
      applyStimulus(1'b0, 1'b1, 8'h05);
      step();

      $display("[TB] snoops on line 0x05");
      applySnoop(1'b1, 3'd1, 8'h05);
      step();
      applySnoop(1'b0, 3'd0, 8'h00);
      checkOutput("snp_rd_wb", 32'(snoop_wb), 32'd1);
      checkLine("snp_rd_line", 2'd1, 2'b01);
      step();
      checkOutput("snp_rd_wb_pulse", 32'(snoop_wb), 32'd0);
      applySnoop(1'b1, 3'd2, 8'h05);
      step();
      applySnoop(1'b0, 3'd0, 8'h00);
      checkOutput("snp_wr_no_wb", 32'(snoop_wb), 32'd0);
      checkLine("snp_wr_line", 2'd1, 2'b00);

      $display("[TB] snoop invalidate during upgrade");
      applyStimulus(1'b1, 1'b0, 8'h05);
      step();
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      applyStimulus(1'b0, 1'b0, 8'h05);
      step();
      checkLine("race_pre_line", 2'd1, 2'b01);
      applyStimulus(1'b1, 1'b1, 8'h05);
      step();
      checkOutput("race_upg_cmd", 32'(bus_cmd), 32'd3);
      applySnoop(1'b1, 3'd3, 8'h05);
      step();
      applySnoop(1'b0, 3'd0, 8'h00);
      checkOutput("race_req", 32'(bus_req), 32'd1);
      checkOutput("race_cmd", 32'(bus_cmd), 32'd2);
      checkOutput("race_addr", 32'(bus_addr), 32'h05);
      checkLine("race_line_inv", 2'd1, 2'b00);
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      checkOutput("race_done", 32'(cpu_done), 32'd1);
      checkOutput("race_hit", 32'(cpu_hit), 32'd0);
      checkLine("race_line", 2'd1, 2'b10);
      applyStimulus(1'b0, 1'b1, 8'h05);
      step();

      $display("[TB] cpu request blocked by concurrent snoop");
      applyStimulus(1'b1, 1'b0, 8'h05);
      applySnoop(1'b1, 3'd1, 8'h02);
      step();
      applySnoop(1'b0, 3'd0, 8'h00);
      checkOutput("block_no_done", 32'(cpu_done), 32'd0);
      step();
      checkOutput("block_done", 32'(cpu_done), 32'd1);
      checkOutput("block_hit", 32'(cpu_hit), 32'd1);
      applyStimulus(1'b0, 1'b0, 8'h05);
      step();

      $display("[TB] reset during miss");
      applyStimulus(1'b1, 1'b0, 8'h0A);
      step();
      checkOutput("rstmiss_req", 32'(bus_req), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("rstmiss_req_drop", 32'(bus_req), 32'd0);
      checkOutput("rstmiss_cmd", 32'(bus_cmd), 32'd0);
      checkLine("rstmiss_line1", 2'd1, 2'b00);
      applyStimulus(1'b0, 1'b0, 8'h00);
      step();
      resetn = 1'b1;
      step();
      checkOutput("post_rst_req", 32'(bus_req), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
